// File: rtl/wb_arbiter_scoreboard.sv
// Write-back arbiter with registered regfile write port and 64-entry pending-write scoreboard.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (lowest index) otherwise.
module wb_arbiter_scoreboard #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 6,
    parameter int unsigned DW   = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NREQ-1:0]    wb_valid_i,
    output logic [NREQ-1:0]    wb_ready_o,
    input  logic [NREQ*AW-1:0] wb_addr_i,
    input  logic [NREQ*DW-1:0] wb_data_i,
    output logic               rf_write_enable_o,
    output logic [AW-1:0]      rf_write_addr_o,
    output logic [DW-1:0]      rf_write_data_o,
    input  logic               iss_valid_i,
    input  logic [AW-1:0]      iss_addr_i,
    output logic               iss_ready_o,
    input  logic [AW-1:0]      chk_addr1_i,
    input  logic [AW-1:0]      chk_addr2_i,
    output logic               chk_busy1_o,
    output logic               chk_busy2_o
);

    localparam int unsigned NREG = 1 << AW;
    localparam int unsigned IdxW = $clog2(NREQ);

    logic [IdxW-1:0] sel;
    logic            grant_any;
    logic            hs;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic [IdxW-1:0] rr_q, rr_d;
    logic [IdxW:0]   rr_sum;

    // Scan requesters starting at the round-robin pointer, wrapping at NREQ.
    always_comb begin
        sel       = '0;
        grant_any = 1'b0;
        rr_sum    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            rr_sum = {1'b0, rr_q} + (IdxW+1)'(k);
            if (rr_sum >= (IdxW+1)'(NREQ)) begin
                rr_sum = rr_sum - (IdxW+1)'(NREQ);
            end
            if (!grant_any && wb_valid_i[rr_sum[IdxW-1:0]]) begin
                grant_any = 1'b1;
                sel       = rr_sum[IdxW-1:0];
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (hs) begin
            rr_d = (sel == IdxW'(NREQ - 1)) ? '0 : sel + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    always_comb begin
        sel       = '0;
        grant_any = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!grant_any && wb_valid_i[k]) begin
                grant_any = 1'b1;
                sel       = IdxW'(k);
            end
        end
    end
`endif

    // No grants while in reset so nothing new gets staged.
    assign hs         = grant_any & ~rst_i;
    assign wb_ready_o = hs ? (NREQ'(1) << sel) : '0;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (IdxW'(k) == sel) begin
                sel_addr = wb_addr_i[k*AW +: AW];
                sel_data = wb_data_i[k*DW +: DW];
            end
        end
    end

    // Registered regfile write stage
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;

    always_comb begin
        we_d   = hs && (sel_addr != '0);
        addr_d = addr_q;
        data_d = data_q;
        if (hs) begin
            addr_d = sel_addr;
            data_d = sel_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign rf_write_enable_o = we_q;
    assign rf_write_addr_o   = addr_q;
    assign rf_write_data_o   = data_q;

    // Scoreboard
    logic [NREG-1:0] pending_q, pending_d;

    // Uses the pre-clear state, so a claim stalls even in the cycle its bit clears.
    assign iss_ready_o = (iss_addr_i == '0) | ~pending_q[iss_addr_i];

    always_comb begin
        pending_d = pending_q;
        if (we_q) begin
            pending_d[addr_q] = 1'b0;
        end
        if (iss_valid_i && iss_ready_o && (iss_addr_i != '0)) begin
            pending_d[iss_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign chk_busy1_o = (chk_addr1_i != '0) & pending_q[chk_addr1_i];
    assign chk_busy2_o = (chk_addr2_i != '0) & pending_q[chk_addr2_i];

endmodule

// File: tb/tb_wb_arbiter_scoreboard.sv
// Self-checking bench for wb_arbiter_scoreboard: directed steps then random traffic vs. a reference model.
module tb_wb_arbiter_scoreboard;

    localparam int NREQ = 3;
    localparam int AW   = 6;
    localparam int DW   = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    wb_valid;
    logic [NREQ-1:0]    wb_ready;
    logic [NREQ*AW-1:0] wb_addr;
    logic [NREQ*DW-1:0] wb_data;
    logic               rf_we;
    logic [AW-1:0]      rf_addr;
    logic [DW-1:0]      rf_data;
    logic               iss_valid;
    logic [AW-1:0]      iss_addr;
    logic               iss_ready;
    logic [AW-1:0]      chk_addr1;
    logic [AW-1:0]      chk_addr2;
    logic               chk_busy1;
    logic               chk_busy2;

    always #5 clk = ~clk;

    wb_arbiter_scoreboard #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .wb_valid_i       (wb_valid),
        .wb_ready_o       (wb_ready),
        .wb_addr_i        (wb_addr),
        .wb_data_i        (wb_data),
        .rf_write_enable_o(rf_we),
        .rf_write_addr_o  (rf_addr),
        .rf_write_data_o  (rf_data),
        .iss_valid_i      (iss_valid),
        .iss_addr_i       (iss_addr),
        .iss_ready_o      (iss_ready),
        .chk_addr1_i      (chk_addr1),
        .chk_addr2_i      (chk_addr2),
        .chk_busy1_o      (chk_busy1),
        .chk_busy2_o      (chk_busy2)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit             pend[64];
    bit             e_we;
    logic [AW-1:0]  e_addr;
    logic [DW-1:0]  e_data;
    bit             addr_known;
    bit             model_valid = 1'b0;
`ifdef WB_ARB_ROUND_ROBIN_EN
    int             rr;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs mid-cycle, then advance the model at the posedge.
    task automatic cycle();
        int            sel;
        bit            ir;
        logic [AW-1:0] a;
        logic [NREQ-1:0] g;
        #3;
        sel = -1;
        if (!rst) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
            for (int k = 0; k < NREQ; k++) begin
                if (sel < 0 && wb_valid[(rr + k) % NREQ]) sel = (rr + k) % NREQ;
            end
`else
            for (int i = 0; i < NREQ; i++) begin
                if (sel < 0 && wb_valid[i]) sel = i;
            end
`endif
        end
        g = '0;
        if (sel >= 0) g[sel] = 1'b1;
        chk("wb_ready", 64'(wb_ready), 64'(g));
        ir = (iss_addr == 0) || !pend[iss_addr];
        if (model_valid) begin
            chk("iss_ready", 64'(iss_ready), 64'(ir));
            chk("chk_busy1", 64'(chk_busy1), 64'((chk_addr1 != 0) && pend[chk_addr1]));
            chk("chk_busy2", 64'(chk_busy2), 64'((chk_addr2 != 0) && pend[chk_addr2]));
            chk("rf_we", 64'(rf_we), 64'(e_we));
            if (addr_known) begin
                chk("rf_addr", 64'(rf_addr), 64'(e_addr));
                chk("rf_data", 64'(rf_data), 64'(e_data));
            end
        end
        @(posedge clk);
        if (rst) begin
            foreach (pend[i]) pend[i] = 1'b0;
            e_we = 0; e_addr = '0; e_data = '0; addr_known = 1; model_valid = 1;
`ifdef WB_ARB_ROUND_ROBIN_EN
            rr = 0;
`endif
        end else begin
            if (e_we) pend[e_addr] = 1'b0;
            if (iss_valid && ir && iss_addr != 0) pend[iss_addr] = 1'b1;
            if (sel >= 0) begin
                a          = wb_addr[sel*AW +: AW];
                e_we       = (a != 0);
                e_addr     = a;
                e_data     = wb_data[sel*DW +: DW];
                addr_known = (a != 0);
`ifdef WB_ARB_ROUND_ROBIN_EN
                rr = (sel + 1) % NREQ;
`endif
            end else begin
                e_we = 0;
            end
        end
        #1;
    endtask

    task automatic set_wb(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_addr[i*AW +: AW] = a;
        wb_data[i*DW +: DW] = d;
    endtask

    initial begin
        // Reset with every input active
        rst = 1; wb_valid = '1; wb_addr = '1; wb_data = '1;
        iss_valid = 1; iss_addr = 6'd3; chk_addr1 = 6'd3; chk_addr2 = 6'd63;
        @(posedge clk); #1;
        cycle(); cycle();
        rst = 0; wb_valid = '0; iss_valid = 0;
        cycle();

        // Single write from requester 1
        set_wb(1, 6'd5, 64'hDEAD); wb_valid = 3'b010;
        cycle();
        wb_valid = '0;
        cycle(); cycle();

        // Contention
        set_wb(0, 6'd1, 64'h11); set_wb(1, 6'd2, 64'h22); set_wb(2, 6'd3, 64'h33);
        wb_valid = 3'b111;
        cycle(); cycle(); cycle();
        wb_valid = '0;
        cycle();

        // x0 claim and x0 write-back
        iss_valid = 1; iss_addr = 6'd0; chk_addr1 = 6'd0;
        cycle();
        iss_valid = 0; set_wb(0, 6'd0, 64'hBAD); wb_valid = 3'b001;
        cycle();
        wb_valid = '0;
        cycle(); cycle();

        // Scoreboard set / stall / clear on r7
        iss_valid = 1; iss_addr = 6'd7; chk_addr1 = 6'd7; chk_addr2 = 6'd5;
        cycle(); cycle();
        iss_valid = 0;
        cycle(); cycle();
        set_wb(2, 6'd7, 64'h7777); wb_valid = 3'b100;
        cycle();
        wb_valid = '0; iss_valid = 1;
        cycle(); cycle();
        iss_valid = 0; set_wb(0, 6'd7, 64'h7); wb_valid = 3'b001;
        cycle();
        wb_valid = '0;
        cycle(); cycle();

        // Reset while a write is staged
        iss_valid = 1; iss_addr = 6'd9; chk_addr1 = 6'd9;
        cycle();
        iss_valid = 0; set_wb(1, 6'd9, 64'h9999); wb_valid = 3'b010;
        cycle();
        wb_valid = '0; rst = 1;
        cycle();
        rst = 0;
        cycle(); cycle();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 59) == 0);
            wb_valid  = NREQ'($urandom_range(0, 7));
            for (int i = 0; i < NREQ; i++) begin
                set_wb(i, AW'($urandom_range(0, 9)), {$urandom, $urandom});
            end
            iss_valid = $urandom_range(0, 1) == 1;
            iss_addr  = ($urandom_range(0, 15) == 0) ? 6'd63 : AW'($urandom_range(0, 9));
            chk_addr1 = AW'($urandom_range(0, 9));
            chk_addr2 = ($urandom_range(0, 7) == 0) ? 6'd63 : AW'($urandom_range(0, 9));
            cycle();
        end
        rst = 0; wb_valid = '0; iss_valid = 0;
        cycle(); cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
